// File: rtl/spi_port_pkg.sv
// Shared types and constants for the ASIC-side parallel-SPI responder.
package spi_port_pkg;

    localparam int DATA_W_DEF = 128;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RX   = 3'd2,
        TX   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous RX FIFO with full/empty flags and a registered near-full flag.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module spi_rx_fifo #(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 8,
    parameter int NF_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              near_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nx;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = pop & ~empty;
    assign wr_ok = push & (~full | rd_ok);
    // Head reads as zero while empty so the output never shows stale storage.
    assign head  = empty ? '0 : mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nx = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nx = count + CW'(1);
            2'b01:   count_nx = count - CW'(1);
            default: count_nx = count;
        endcase
    end

    // Pointers, occupancy and near-full flag; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            near_full <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nx;
            near_full <= ((CW'(DEPTH) - count_nx) <= CW'(NF_MARGIN));
        end
    end

    // Storage; contents need no reset since head is gated by empty.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/asic_spi_port.sv
// ASIC-side responder of the 128-bit parallel-SPI link.
// sck, cs_n, data and OE grant are oversampled on I_clk (I_clk >= 8x sck).
// Optional macro SPI_PORT_RX_XSUM_EN builds the RX XOR checksum on O_rx_xsum.
//
// state | meaning
// IDLE  | waiting for I_cfg_start
// REQ   | O_config_req raised, waiting for FPGA to pull cs_n low
// RX    | FPGA->ASIC, each sck rise pushes one word into the RX FIFO
// TX    | ASIC->FPGA, each sck rise retires the presented word
// DONE  | all words moved, waiting for cs_n release
module asic_spi_port
    import spi_port_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RX_DEPTH  = 8,
    parameter int NF_MARGIN = 2,
    parameter int LEN_W     = 8
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_spi_cs_n,
    input  logic              I_spi_sck,
    input  logic [DATA_W-1:0] I_spi_data,
    output logic [DATA_W-1:0] O_spi_data,
    output logic              O_spi_data_oe,
    input  logic              I_OE_req,
    output logic              O_config_req,
    output logic              O_switch_rdwr,
    output logic              O_near_full,
    input  logic              I_cfg_start,
    input  logic              I_cfg_dir,
    input  logic [LEN_W-1:0]  I_cfg_len,
    output logic [DATA_W-1:0] O_rx_data,
    output logic              O_rx_vld,
    input  logic              I_rx_rdy,
    input  logic [DATA_W-1:0] I_tx_data,
    input  logic              I_tx_vld,
    output logic              O_tx_rdy,
    output logic              O_done,
    output logic              O_err,
    output logic [DATA_W-1:0] O_rx_xsum
);
    state_t            state;
    logic              sck_s1, sck_s2, sck_d;
    logic              cs_s1, cs_s2;
    logic              oe_s1, oe_s2;
    logic [DATA_W-1:0] data_s1, data_s2;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  cnt;
    logic              sck_rise;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rx_drop;

    // Two-flop synchronisers; data shares the depth so it stays aligned with sck.
    // cs_n resets high so no phantom select is seen out of reset.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            oe_s1   <= 1'b0;
            oe_s2   <= 1'b0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            sck_s1  <= I_spi_sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            cs_s1   <= I_spi_cs_n;
            cs_s2   <= cs_s1;
            oe_s1   <= I_OE_req;
            oe_s2   <= oe_s1;
            data_s1 <= I_spi_data;
            data_s2 <= data_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_d & ~cs_s2;
    assign push     = (state == RX) & sck_rise;
    assign pop      = O_rx_vld & I_rx_rdy;
    assign rx_drop  = push & fifo_full & ~pop;
    assign O_rx_vld = ~fifo_empty;

    spi_rx_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (RX_DEPTH),
        .NF_MARGIN (NF_MARGIN)
    ) u_rx_fifo (
        .clk       (I_clk),
        .rst       (I_rst),
        .push      (push),
        .push_data (data_s2),
        .pop       (pop),
        .head      (O_rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .near_full (O_near_full)
    );

    // Transfer sequencer with registered handshake, bus and status outputs.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state         <= IDLE;
            len_r         <= '0;
            cnt           <= '0;
            O_spi_data    <= '0;
            O_spi_data_oe <= 1'b0;
            O_config_req  <= 1'b0;
            O_switch_rdwr <= 1'b0;
            O_tx_rdy      <= 1'b0;
            O_done        <= 1'b0;
            O_err         <= 1'b0;
        end else begin
            O_tx_rdy      <= 1'b0;
            O_done        <= 1'b0;
            O_spi_data_oe <= 1'b0;
            if (rx_drop) O_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (I_cfg_start) begin
                        O_switch_rdwr <= I_cfg_dir;
                        len_r         <= I_cfg_len;
                        cnt           <= '0;
                        O_err         <= 1'b0;
                        O_config_req  <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (!cs_s2) begin
                        O_config_req <= 1'b0;
                        if (O_switch_rdwr == DIR_TX) begin
                            O_spi_data_oe <= oe_s2;
                            if (I_tx_vld) begin
                                O_spi_data <= I_tx_data;
                                O_tx_rdy   <= 1'b1;
                            end else begin
                                O_spi_data <= '0;
                                O_err      <= 1'b1;
                            end
                            state <= TX;
                        end else begin
                            state <= RX;
                        end
                    end
                end
                RX: begin
                    if (cs_s2) begin
                        O_err         <= 1'b1;
                        O_done        <= 1'b1;
                        O_switch_rdwr <= 1'b0;
                        cnt           <= '0;
                        state         <= IDLE;
                    end else if (sck_rise) begin
                        if (cnt == len_r) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                TX: begin
                    if (cs_s2) begin
                        O_err         <= 1'b1;
                        O_done        <= 1'b1;
                        O_switch_rdwr <= 1'b0;
                        cnt           <= '0;
                        state         <= IDLE;
                    end else begin
                        O_spi_data_oe <= oe_s2;
                        if (sck_rise) begin
                            if (cnt == len_r) begin
                                cnt           <= '0;
                                O_spi_data_oe <= 1'b0;
                                state         <= DONE;
                            end else begin
                                cnt <= cnt + LEN_W'(1);
                                if (I_tx_vld) begin
                                    O_spi_data <= I_tx_data;
                                    O_tx_rdy   <= 1'b1;
                                end else begin
                                    O_spi_data <= '0;
                                    O_err      <= 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (cs_s2) begin
                        O_done        <= 1'b1;
                        O_switch_rdwr <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_PORT_RX_XSUM_EN
    // XOR of every word seen on an RX sck rise, dropped words included.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst)                            O_rx_xsum <= '0;
        else if (state == IDLE && I_cfg_start) O_rx_xsum <= '0;
        else if (push)                        O_rx_xsum <= O_rx_xsum ^ data_s2;
    end
`else
    assign O_rx_xsum = '0;
`endif

endmodule
